// File: rtl/id_stage.sv
// RV32I decode stage: latches one instruction, decodes it and issues it to the register-file stage.
// Latency: issue pulse one cycle after the accept edge; back-to-back accept when rf_done arrives in BUSY.
// Backpressure: id_ready low while an instruction is issued or awaiting rf_done, and whenever flush is high.
module id_stage #(
   parameter int COLS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_id_valid,
   input  logic [31:0]     if_id_instr,
   input  logic [COLS-1:0] if_id_pc,
   input  logic            rf_done,
   input  logic            flush,
   output logic            id_ready,
   output logic            id_rf_valid_inst,
   output logic [4:0]      decode_addr,
   output logic [4:0]      rd_index,
   output logic [4:0]      rs1_index,
   output logic [4:0]      rs2_index,
   output logic [COLS-1:0] immediate,
   output logic [COLS-1:0] pc_reg,
   output logic [COLS-1:0] pc_plus4,
   output logic [1:0]      id_rf_shift_controls,
   output logic            id_illegal
);

   typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [4:0] ADDR_ILL  = 5'd31;

   state_t state_q, state_d;

   logic [6:0]      opcode, funct7;
   logic [2:0]      funct3;
   logic [COLS-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
   logic [4:0]      dec_addr;
   logic [COLS-1:0] dec_imm;
   logic [1:0]      dec_shift;
   logic            dec_legal, accept;

   assign opcode = if_id_instr[6:0];
   assign funct3 = if_id_instr[14:12];
   assign funct7 = if_id_instr[31:25];

   assign imm_i  = COLS'($signed(if_id_instr[31:20]));
   assign imm_s  = COLS'($signed({if_id_instr[31:25], if_id_instr[11:7]}));
   assign imm_b  = COLS'($signed({if_id_instr[31], if_id_instr[7], if_id_instr[30:25],
                                  if_id_instr[11:8], 1'b0}));
   assign imm_u  = COLS'($signed({if_id_instr[31:12], 12'b0}));
   assign imm_j  = COLS'($signed({if_id_instr[31], if_id_instr[19:12], if_id_instr[20],
                                  if_id_instr[30:21], 1'b0}));
   assign imm_sh = COLS'(if_id_instr[24:20]);

   always_comb begin
      dec_addr  = ADDR_ILL;
      dec_imm   = '0;
      dec_shift = 2'b00;
      case (opcode)
         OP_R: begin
            case ({funct7, funct3})
               {7'h00, 3'd0}: dec_addr = 5'd0;
               {7'h20, 3'd0}: dec_addr = 5'd1;
               {7'h00, 3'd1}: dec_addr = 5'd2;
               {7'h00, 3'd2}: dec_addr = 5'd3;
               {7'h00, 3'd3}: dec_addr = 5'd4;
               {7'h00, 3'd4}: dec_addr = 5'd5;
               {7'h00, 3'd5}: begin dec_addr = 5'd6; dec_shift = 2'b01; end
               {7'h20, 3'd5}: begin dec_addr = 5'd7; dec_shift = 2'b11; end
               {7'h00, 3'd6}: dec_addr = 5'd8;
               {7'h00, 3'd7}: dec_addr = 5'd9;
               default:       dec_addr = ADDR_ILL;
            endcase
         end
         OP_IMM: begin
            dec_imm = imm_i;
            case (funct3)
               3'd0: dec_addr = 5'd10;
               3'd2: dec_addr = 5'd11;
               3'd3: dec_addr = 5'd12;
               3'd4: dec_addr = 5'd13;
               3'd6: dec_addr = 5'd14;
               3'd7: dec_addr = 5'd15;
               3'd1: begin
                  dec_imm = imm_sh;
                  if (funct7 == 7'h00) dec_addr = 5'd16;
               end
               default: begin
                  dec_imm = imm_sh;
                  if (funct7 == 7'h00) begin
                     dec_addr  = 5'd17;
                     dec_shift = 2'b01;
                  end else if (funct7 == 7'h20) begin
                     dec_addr  = 5'd18;
                     dec_shift = 2'b11;
                  end
               end
            endcase
         end
         OP_LOAD:   if (funct3 == 3'd2) begin dec_addr = 5'd19; dec_imm = imm_i; end
         OP_STORE:  if (funct3 == 3'd2) begin dec_addr = 5'd20; dec_imm = imm_s; end
         OP_LUI:    begin dec_addr = 5'd21; dec_imm = imm_u; end
         OP_AUIPC:  begin dec_addr = 5'd22; dec_imm = imm_u; end
         OP_JAL:    begin dec_addr = 5'd23; dec_imm = imm_j; end
         OP_JALR:   if (funct3 == 3'd0) begin dec_addr = 5'd24; dec_imm = imm_i; end
         OP_BRANCH: begin dec_addr = 5'd25; dec_imm = imm_b; end
         default:   dec_addr = ADDR_ILL;
      endcase
      // Undecodable words leave a clean zero immediate and shift field behind.
      if (dec_addr == ADDR_ILL) begin
         dec_imm   = '0;
         dec_shift = 2'b00;
      end
   end

   assign dec_legal = (dec_addr != ADDR_ILL);

   always_comb begin
      id_ready = 1'b0;
      state_d  = state_q;
      if (!flush)
         id_ready = (state_q == IDLE) || ((state_q == BUSY) && rf_done);
      accept = if_id_valid && id_ready;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (accept && dec_legal) state_d = ISSUE;
            ISSUE:   state_d = BUSY;
            BUSY:    if (rf_done) state_d = (accept && dec_legal) ? ISSUE : IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // A flush arriving in the ISSUE cycle suppresses the pulse already on its way out.
   assign id_rf_valid_inst = (state_q == ISSUE) && !flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q              <= IDLE;
         id_illegal           <= 1'b0;
         decode_addr          <= '0;
         rd_index             <= '0;
         rs1_index            <= '0;
         rs2_index            <= '0;
         immediate            <= '0;
         pc_reg               <= '0;
         pc_plus4             <= '0;
         id_rf_shift_controls <= '0;
      end else begin
         state_q    <= state_d;
         id_illegal <= accept && !dec_legal;
         if (accept) begin
            decode_addr          <= dec_addr;
            rd_index             <= if_id_instr[11:7];
            rs1_index            <= if_id_instr[19:15];
            rs2_index            <= if_id_instr[24:20];
            immediate            <= dec_imm;
            pc_reg               <= if_id_pc;
            pc_plus4             <= if_id_pc + COLS'(4);
            id_rf_shift_controls <= dec_shift;
         end
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: a transaction-level model tracks the expected outputs every cycle,
// and hand-computed literals pin the model on the documented example instructions.
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_id_valid = 1'b0;
   logic [31:0] if_id_instr = '0;
   logic [31:0] if_id_pc = '0;
   logic        rf_done = 1'b0;
   logic        flush = 1'b0;
   logic        id_ready, id_rf_valid_inst, id_illegal;
   logic [4:0]  decode_addr, rd_index, rs1_index, rs2_index;
   logic [31:0] immediate, pc_reg, pc_plus4;
   logic [1:0]  id_rf_shift_controls;

   id_stage #(.COLS(32)) dut (
      .clk(clk), .rst(rst),
      .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
      .rf_done(rf_done), .flush(flush),
      .id_ready(id_ready), .id_rf_valid_inst(id_rf_valid_inst),
      .decode_addr(decode_addr), .rd_index(rd_index), .rs1_index(rs1_index),
      .rs2_index(rs2_index), .immediate(immediate), .pc_reg(pc_reg), .pc_plus4(pc_plus4),
      .id_rf_shift_controls(id_rf_shift_controls), .id_illegal(id_illegal)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   // Model: an issue pulse due this cycle, an instruction awaiting rf_done, and the latched decode.
   logic        m_pulse, m_wait, m_ill;
   logic [4:0]  m_addr, m_rd, m_rs1, m_rs2;
   logic [31:0] m_imm, m_pc, m_pc4;
   logic [1:0]  m_sh;

   localparam logic [31:0] ADDI  = 32'hFFD08293;
   localparam logic [31:0] SRAI  = 32'h40725193;
   localparam logic [31:0] SW    = 32'h0020A423;
   localparam logic [31:0] LUI   = 32'h123450B7;
   localparam logic [31:0] BAD   = 32'hFFFFFFFF;
   localparam logic [31:0] SLLIB = 32'h40001013;
   localparam logic [31:0] SRL   = 32'h0020D1B3;
   localparam logic [31:0] SUB   = 32'h40208133;
   localparam logic [31:0] JAL0  = 32'h0000006F;
   localparam logic [31:0] BEQN  = 32'hFE000EE3;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
   endtask

   function automatic void ref_decode(input logic [31:0] w, output logic [4:0] a,
                                      output logic [31:0] imm, output logic [1:0] sh);
      logic [6:0] op, f7;
      logic [2:0] f3;
      int r_norm [8];
      int r_imm [8];
      op = w[6:0];
      f3 = w[14:12];
      f7 = w[31:25];
      r_norm = '{0, 2, 3, 4, 5, 6, 8, 9};
      r_imm  = '{10, 16, 11, 12, 13, 17, 14, 15};
      a = 5'd31;
      imm = 32'd0;
      if (op == 7'h33) begin
         imm = 32'd0;
         if (f7 == 7'h00) a = 5'(r_norm[f3]);
         else if (f7 == 7'h20 && f3 == 3'd0) a = 5'd1;
         else if (f7 == 7'h20 && f3 == 3'd5) a = 5'd7;
      end else if (op == 7'h13) begin
         a = 5'(r_imm[f3]);
         imm = {{20{w[31]}}, w[31:20]};
         if (f3 == 3'd1 || f3 == 3'd5) begin
            imm = {27'd0, w[24:20]};
            if (f3 == 3'd5 && f7 == 7'h20) a = 5'd18;
            else if (f7 != 7'h00) a = 5'd31;
         end
      end else if (op == 7'h03 && f3 == 3'd2) begin
         a = 5'd19; imm = {{20{w[31]}}, w[31:20]};
      end else if (op == 7'h23 && f3 == 3'd2) begin
         a = 5'd20; imm = {{20{w[31]}}, w[31:25], w[11:7]};
      end else if (op == 7'h37 || op == 7'h17) begin
         a = (op == 7'h37) ? 5'd21 : 5'd22; imm = {w[31:12], 12'd0};
      end else if (op == 7'h6F) begin
         a = 5'd23; imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
      end else if (op == 7'h67 && f3 == 3'd0) begin
         a = 5'd24; imm = {{20{w[31]}}, w[31:20]};
      end else if (op == 7'h63) begin
         a = 5'd25; imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
      end
      sh = (a == 5'd6 || a == 5'd17) ? 2'b01 : (a == 5'd7 || a == 5'd18) ? 2'b11 : 2'b00;
      if (a == 5'd31) imm = 32'd0;
   endfunction

   function automatic logic exp_ready();
      return !flush && !m_pulse && (!m_wait || rf_done);
   endfunction

   task automatic model_clear();
      {m_pulse, m_wait, m_ill, m_addr, m_rd, m_rs1, m_rs2} = '0;
      {m_imm, m_pc, m_pc4, m_sh} = '0;
   endtask

   task automatic compare_all();
      chk("id_ready", 32'(id_ready), 32'(exp_ready()));
      chk("issue", 32'(id_rf_valid_inst), 32'(m_pulse && !flush));
      chk("illegal", 32'(id_illegal), 32'(m_ill));
      chk("decode_addr", 32'(decode_addr), 32'(m_addr));
      chk("rd", 32'(rd_index), 32'(m_rd));
      chk("rs1", 32'(rs1_index), 32'(m_rs1));
      chk("rs2", 32'(rs2_index), 32'(m_rs2));
      chk("immediate", immediate, m_imm);
      chk("pc_reg", pc_reg, m_pc);
      chk("pc_plus4", pc_plus4, m_pc4);
      chk("shift", 32'(id_rf_shift_controls), 32'(m_sh));
   endtask

   // Advance the model across the coming rising edge using the inputs now applied.
   task automatic model_step();
      logic [4:0] a;
      logic [31:0] imm;
      logic [1:0] sh;
      logic acc;
      acc = if_id_valid && exp_ready();
      ref_decode(if_id_instr, a, imm, sh);
      if (flush) begin
         m_pulse = 1'b0; m_wait = 1'b0;
      end else if (m_pulse) begin
         m_pulse = 1'b0; m_wait = 1'b1;
      end else begin
         if (rf_done) m_wait = 1'b0;
         if (acc && a != 5'd31) m_pulse = 1'b1;
      end
      m_ill = acc && (a == 5'd31);
      if (acc) begin
         m_addr = a; m_imm = imm; m_sh = sh;
         m_rd = if_id_instr[11:7]; m_rs1 = if_id_instr[19:15]; m_rs2 = if_id_instr[24:20];
         m_pc = if_id_pc; m_pc4 = if_id_pc + 32'd4;
      end
   endtask

   task automatic cyc(input logic v, input logic [31:0] w, input logic [31:0] pc,
                      input logic d, input logic f);
      @(posedge clk);
      #1;
      if_id_valid = v; if_id_instr = w; if_id_pc = pc; rf_done = d; flush = f;
      @(negedge clk);
      compare_all();
      model_step();
   endtask

   initial begin
      model_clear();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      chk("rst id_ready", 32'(id_ready), 32'd1);
      chk("rst decode_addr", 32'(decode_addr), 32'd0);
      chk("rst pc_plus4", pc_plus4, 32'd0);
      compare_all();
      model_step();

      cyc(1, ADDI, 32'h100, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("addi issue", 32'(id_rf_valid_inst), 32'd1);
      chk("addi addr", 32'(decode_addr), 32'd10);
      chk("addi rd", 32'(rd_index), 32'd5);
      chk("addi rs1", 32'(rs1_index), 32'd1);
      chk("addi imm", immediate, 32'hFFFFFFFD);
      chk("addi pc4", pc_plus4, 32'h104);
      chk("addi ready", 32'(id_ready), 32'd0);
      cyc(0, 0, 0, 0, 0);
      chk("busy ready", 32'(id_ready), 32'd0);
      cyc(1, SRAI, 32'h104, 1, 0);
      chk("done ready", 32'(id_ready), 32'd1);
      cyc(0, 0, 0, 0, 0);
      chk("srai addr", 32'(decode_addr), 32'd18);
      chk("srai imm", immediate, 32'd7);
      chk("srai shift", 32'(id_rf_shift_controls), 32'd3);
      cyc(0, 0, 0, 1, 0);
      cyc(1, SW, 32'h108, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("sw addr", 32'(decode_addr), 32'd20);
      chk("sw imm", immediate, 32'd8);
      cyc(1, LUI, 32'h10C, 1, 0);
      cyc(0, 0, 0, 0, 0);
      chk("lui issue", 32'(id_rf_valid_inst), 32'd1);
      chk("lui addr", 32'(decode_addr), 32'd21);
      chk("lui imm", immediate, 32'h12345000);
      cyc(0, 0, 0, 1, 0);

      cyc(1, BAD, 32'h200, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("bad addr", 32'(decode_addr), 32'd31);
      chk("bad illegal", 32'(id_illegal), 32'd1);
      chk("bad issue", 32'(id_rf_valid_inst), 32'd0);
      chk("bad ready", 32'(id_ready), 32'd1);
      cyc(1, SLLIB, 32'h204, 0, 0);
      cyc(0, 0, 0, 1, 0);
      chk("slli f7 illegal", 32'(id_illegal), 32'd1);

      cyc(1, SRL, 32'h300, 0, 1);
      cyc(0, 0, 0, 0, 0);
      chk("flush accept issue", 32'(id_rf_valid_inst), 32'd0);
      chk("flush hold addr", 32'(decode_addr), 32'd31);
      cyc(1, SRL, 32'h300, 0, 0);
      cyc(0, 0, 0, 0, 1);
      chk("flush issue", 32'(id_rf_valid_inst), 32'd0);
      cyc(0, 0, 0, 0, 0);
      chk("flush idle", 32'(id_ready), 32'd1);
      chk("srl shift", 32'(id_rf_shift_controls), 32'd1);

      cyc(1, SUB, 32'h400, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      #1 rst = 1'b0;
      #1;
      model_clear();
      chk("arst addr", 32'(decode_addr), 32'd0);
      chk("arst pc4", pc_plus4, 32'd0);
      chk("arst ready", 32'(id_ready), 32'd1);
      compare_all();
      @(negedge clk);
      rst = 1'b1;

      cyc(1, JAL0, 32'hFFFFFFFC, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("jal issue", 32'(id_rf_valid_inst), 32'd1);
      chk("jal addr", 32'(decode_addr), 32'd23);
      chk("jal pc4", pc_plus4, 32'd0);
      cyc(0, 0, 0, 0, 0);
      cyc(1, BEQN, 32'h500, 1, 0);
      cyc(0, 0, 0, 0, 0);
      chk("beq addr", 32'(decode_addr), 32'd25);
      chk("beq imm", immediate, 32'hFFFFFFFC);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
